// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  localparam int unsigned SUB_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : sub_pkg

// File: rtl/bitwise_full_subtractor.sv
// One-bit full subtractor slice: d = a - b - bin, with borrow out.
module bitwise_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : bitwise_full_subtractor

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor slice, registered borrow, LSB first,
// with a start/busy/done handshake toward a controlling FSM.
module serial_ripple_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned N = SUB_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         borrow_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] difference,
  output logic         borrow_out
);

  localparam int unsigned CNT_W = $clog2(N);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             accept;
  logic             last;
  logic             busy_d;
  logic             done_d;
  logic [N-1:0]     a_sh;
  logic [N-1:0]     b_sh;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             slice_d;
  logic             slice_bout;

  bitwise_full_subtractor u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // State register plus registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == CNT_W'(N - 1)) begin
          last       = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done come straight off flops.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_next)
      ST_RUN:  busy_d = 1'b1;
      ST_DONE: done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath: operand shifters, borrow register, bit counter, result shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      difference <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      brw  <= borrow_in;
      cnt  <= '0;
    end else if (state == ST_RUN) begin
      a_sh       <= {1'b0, a_sh[N-1:1]};
      b_sh       <= {1'b0, b_sh[N-1:1]};
      brw        <= slice_bout;
      difference <= {slice_d, difference[N-1:1]};
      if (last) begin
        cnt        <= '0;
        borrow_out <= slice_bout;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule : serial_ripple_subtractor

// File: tb/tb_serial_ripple_subtractor.sv
// Directed self-checking bench for serial_ripple_subtractor at N=8.
module tb_serial_ripple_subtractor;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [N-1:0] difference;
  logic         borrow_out;

  int checks = 0;
  int errors = 0;

  serial_ripple_subtractor #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for busy to drop; returns number of busy cycles observed.
  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 4 * N) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // Issue one operation from IDLE and check timing, result and the done pulse.
  task automatic do_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic bi, input logic [N-1:0] exp_d, input logic exp_bo);
    int cyc;
    @(negedge clk);
    a = av; b = bv; borrow_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    wait_busy(cyc);
    check({tag, "_busy_cycles"}, 32'(cyc), 32'(N));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_diff"}, 32'(difference), 32'(exp_d));
    check({tag, "_bout"}, 32'(borrow_out), 32'(exp_bo));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_diff_held"}, 32'(difference), 32'(exp_d));
  endtask

  initial begin
    int cyc;
    logic saw_done;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(difference), 32'd0);
    check("rst_bout", 32'(borrow_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("op_05_03",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    do_op("op_00_01",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    do_op("op_ff_ff_b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    do_op("op_80_7f_b", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

    // start mid-RUN with different operands must be ignored.
    @(negedge clk);
    a = 8'h05; b = 8'h03; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'h11; borrow_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_busy(cyc);
    check("ign_busy_cycles", 32'(cyc), 32'(N - 4));
    check("ign_done", 32'(done), 32'd1);
    check("ign_diff", 32'(difference), 32'h02);
    check("ign_bout", 32'(borrow_out), 32'd0);
    @(negedge clk);
    check("ign_idle", 32'(busy), 32'd0);

    // Reset asserted while processing bit 4.
    @(negedge clk);
    a = 8'h12; b = 8'h03; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(difference), 32'd0);
    check("abort_bout", 32'(borrow_out), 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (N + 2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    do_op("op_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

    // Back-to-back: start held high in DONE is accepted with no IDLE cycle.
    @(negedge clk);
    a = 8'h40; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_busy(cyc);
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_diff", 32'(difference), 32'h3F);
    a = 8'h20; b = 8'h10; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_idle", 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 4 * N) begin
      cyc++;
      @(negedge clk);
    end
    check("b2b_done_gap", 32'(cyc), 32'(N + 1));
    check("b2b_diff", 32'(difference), 32'h10);
    check("b2b_bout", 32'(borrow_out), 32'd0);
    @(negedge clk);
    check("b2b_done_pulse", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_ripple_subtractor
